// File: rtl/memref_port_responder.sv
// Memory-side responder for a single HIR/HLS memref port: pipelined reads with
// programmable latency, writes, saturating access counters and sticky protocol-error flags.
module memref_port_responder #(
  parameter int WIDTH         = 32,
  parameter int SIZE          = 64,
  parameter int ADDR_W        = $clog2(SIZE),
  parameter int RD_LATENCY    = 1,
  parameter int CNT_W         = 16,
  parameter int CHECK_ADDR_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_addr_en,
  input  logic [ADDR_W-1:0] p0_addr_data,
  input  logic              p0_rd_en,
  output logic [WIDTH-1:0]  p0_rd_data,
  output logic              p0_rd_valid,
  input  logic              p0_wr_en,
  input  logic [WIDTH-1:0]  p0_wr_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err_oob,
  output logic              err_rdwr,
  output logic              err_noaddr
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("memref_port_responder: RD_LATENCY must be within 1..4");
  end

  localparam logic [ADDR_W:0] SIZE_C = (ADDR_W + 1)'(SIZE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0]      mem_q [SIZE];
  logic                  addr_ok, req, rd_acc, wr_acc, oob;
  logic [WIDTH-1:0]      rd_word;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  stg_vld;
  logic [WIDTH-1:0]      stg_dat;
  logic [WIDTH-1:0]      rdat_q;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                  err_oob_q, err_oob_d, err_rdwr_q, err_rdwr_d, err_noaddr_q, err_noaddr_d;

  // Request decode; out-of-range reads return zero instead of touching the array.
  always_comb begin
    addr_ok      = (CHECK_ADDR_EN == 0) || p0_addr_en;
    req          = p0_rd_en | p0_wr_en;
    rd_acc       = p0_rd_en & addr_ok;
    wr_acc       = p0_wr_en & addr_ok;
    oob          = {1'b0, p0_addr_data} >= SIZE_C;
    rd_word      = oob ? '0 : mem_q[p0_addr_data];
    rd_cnt_d     = rd_acc ? sat_inc(rd_cnt_q) : rd_cnt_q;
    wr_cnt_d     = wr_acc ? sat_inc(wr_cnt_q) : wr_cnt_q;
    err_oob_d    = err_oob_q | ((rd_acc | wr_acc) & oob);
    err_rdwr_d   = err_rdwr_q | (p0_rd_en & p0_wr_en);
    err_noaddr_d = err_noaddr_q | (req & ~addr_ok);
    vld_d        = '0;
    vld_d[0]     = rd_acc;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  // Array write; the read above samples the old word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_acc && !oob) mem_q[p0_addr_data] <= p0_wr_data;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign stg_vld = rd_acc;
    assign stg_dat = rd_word;
  end else begin : g_pipe
    logic [WIDTH-1:0] dat_q [RD_LATENCY-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY - 1; i++) dat_q[i] <= dat_q[i-1];
    end
    assign stg_vld = vld_q[RD_LATENCY-2];
    assign stg_dat = dat_q[RD_LATENCY-2];
  end

  // Output stage: data register loads only with a valid so it holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q        <= '0;
      rdat_q       <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      err_oob_q    <= 1'b0;
      err_rdwr_q   <= 1'b0;
      err_noaddr_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      if (stg_vld) rdat_q <= stg_dat;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      err_oob_q    <= err_oob_d;
      err_rdwr_q   <= err_rdwr_d;
      err_noaddr_q <= err_noaddr_d;
    end
  end

  assign p0_rd_valid = vld_q[RD_LATENCY-1];
  assign p0_rd_data  = rdat_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign err_oob     = err_oob_q;
  assign err_rdwr    = err_rdwr_q;
  assign err_noaddr  = err_noaddr_q;

endmodule

// File: tb/tb_memref_port_responder.sv
// Scoreboard bench: three responder configurations share one stimulus stream and are
// each compared against a behavioural memory model every cycle.
module tb_memref_port_responder;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, rd_en, wr_en;
  logic [5:0]  addr;
  logic [31:0] wdata;

  logic        rv  [ND];
  logic [31:0] rdd [ND];
  logic [15:0] rc  [ND];
  logic [15:0] wc  [ND];
  logic        eo  [ND];
  logic        erw [ND];
  logic        ena [ND];
  logic [3:0]  rc0, wc0;

  assign rc[0] = {12'd0, rc0};
  assign wc[0] = {12'd0, wc0};

  always #5 clk = ~clk;

  // dut0: SIZE 60, latency 3, address qualifier checked, 4-bit counters
  memref_port_responder #(.WIDTH(32), .SIZE(60), .RD_LATENCY(3), .CNT_W(4), .CHECK_ADDR_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .p0_addr_en(a_en), .p0_addr_data(addr), .p0_rd_en(rd_en),
    .p0_rd_data(rdd[0]), .p0_rd_valid(rv[0]), .p0_wr_en(wr_en), .p0_wr_data(wdata),
    .rd_count(rc0), .wr_count(wc0), .err_oob(eo[0]), .err_rdwr(erw[0]), .err_noaddr(ena[0]));

  // dut1: defaults (SIZE 64, latency 1, qualifier ignored)
  memref_port_responder #(.WIDTH(32), .SIZE(64), .RD_LATENCY(1), .CNT_W(16), .CHECK_ADDR_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .p0_addr_en(a_en), .p0_addr_data(addr), .p0_rd_en(rd_en),
    .p0_rd_data(rdd[1]), .p0_rd_valid(rv[1]), .p0_wr_en(wr_en), .p0_wr_data(wdata),
    .rd_count(rc[1]), .wr_count(wc[1]), .err_oob(eo[1]), .err_rdwr(erw[1]), .err_noaddr(ena[1]));

  // dut2: latency 4
  memref_port_responder #(.WIDTH(32), .SIZE(64), .RD_LATENCY(4), .CNT_W(16), .CHECK_ADDR_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .p0_addr_en(a_en), .p0_addr_data(addr), .p0_rd_en(rd_en),
    .p0_rd_data(rdd[2]), .p0_rd_valid(rv[2]), .p0_wr_en(wr_en), .p0_wr_data(wdata),
    .rd_count(rc[2]), .wr_count(wc[2]), .err_oob(eo[2]), .err_rdwr(erw[2]), .err_noaddr(ena[2]));

  function automatic int p_lat(int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction
  function automatic int p_size(int k);
    return (k == 0) ? 60 : 64;
  endfunction
  function automatic bit p_chk(int k);
    return (k == 0);
  endfunction
  function automatic int p_max(int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  // Reference model state
  typedef struct { int t; logic [31:0] d; } exp_t;
  exp_t        q0[$], q1[$], q2[$];
  logic [31:0] mmem [ND][64];
  int          mrc [ND];
  int          mwc [ND];
  bit          meo [ND];
  bit          merw [ND];
  bit          mena [ND];
  logic [31:0] mlast [ND];
  int          ecnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  function automatic void qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction
  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction
  function automatic exp_t qfront(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction
  function automatic void qpop(int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d edge %0d: got %h, required %h", nm, k, ecnt, act, req);
    end
  endfunction

  // One port transaction as the port rules describe it, applied to configuration k.
  function automatic void model_step(int k);
    bit   ok  = !p_chk(k) || a_en;
    bit   bad = int'(addr) >= p_size(k);
    exp_t e;
    if (rd_en && wr_en) merw[k] = 1'b1;
    if ((rd_en || wr_en) && !ok) mena[k] = 1'b1;
    if ((rd_en || wr_en) && ok) begin
      if (bad) meo[k] = 1'b1;
      if (rd_en) begin
        e.t = ecnt + p_lat(k);
        e.d = bad ? 32'd0 : mmem[k][addr];
        qpush(k, e);
        if (mrc[k] < p_max(k)) mrc[k]++;
      end
      if (wr_en) begin
        if (!bad) mmem[k][addr] = wdata;
        if (mwc[k] < p_max(k)) mwc[k]++;
      end
    end
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete(); q1.delete(); q2.delete();
      for (int k = 0; k < ND; k++) begin
        mrc[k] = 0; mwc[k] = 0; meo[k] = 0; merw[k] = 0; mena[k] = 0; mlast[k] = 32'd0;
      end
    end else begin
      for (int k = 0; k < ND; k++) model_step(k);
    end
  end

  // Monitor: compares every output of every configuration on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (!rst) begin
        chk("rst_valid", k, {31'd0, rv[k]}, 32'd0);
        chk("rst_data", k, rdd[k], 32'd0);
      end else begin
        bit   due;
        exp_t f;
        due = (qsize(k) > 0) && (qfront(k).t == ecnt);
        chk("rd_valid", k, {31'd0, rv[k]}, {31'd0, due});
        if (due) begin
          f = qfront(k);
          chk("rd_data", k, rdd[k], f.d);
          mlast[k] = f.d;
          qpop(k);
        end else begin
          chk("rd_hold", k, rdd[k], mlast[k]);
        end
      end
      chk("rd_count", k, {16'd0, rc[k]}, mrc[k]);
      chk("wr_count", k, {16'd0, wc[k]}, mwc[k]);
      chk("err_oob", k, {31'd0, eo[k]}, {31'd0, meo[k]});
      chk("err_rdwr", k, {31'd0, erw[k]}, {31'd0, merw[k]});
      chk("err_noaddr", k, {31'd0, ena[k]}, {31'd0, mena[k]});
    end
  end

  task automatic drive(bit r, bit w, bit ae, logic [5:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    rd_en = r; wr_en = w; a_en = ae; addr = a; wdata = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1, 6'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; a_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int a = 0; a < 64; a++) drive(1'b0, 1'b1, 1'b1, 6'(a), $urandom);
    pulse_reset();
    idle(2);

    drive(1'b0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b1, 6'd5, 32'd0);
    idle(5);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 6'(i), 32'(i * 3));
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 6'(i), 32'd0);
    idle(6);

    drive(1'b0, 1'b1, 1'b1, 6'd9, 32'h11);
    drive(1'b1, 1'b1, 1'b1, 6'd9, 32'h22);
    drive(1'b1, 1'b0, 1'b1, 6'd9, 32'd0);
    idle(6);

    drive(1'b0, 1'b1, 1'b1, 6'd62, 32'h5A5A_1234);
    drive(1'b1, 1'b0, 1'b1, 6'd62, 32'd0);
    idle(6);

    drive(1'b1, 1'b0, 1'b0, 6'd7, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 6'd7, 32'hBAD0BAD0);
    drive(1'b1, 1'b0, 1'b1, 6'd7, 32'd0);
    idle(6);

    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40, $urandom_range(0, 9) != 0,
            6'($urandom_range(0, 63)), $urandom);
    idle(6);

    drive(1'b1, 1'b0, 1'b1, 6'd3, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 6'd4, 32'd0);
    pulse_reset();
    idle(6);

    for (int a = 0; a < 64; a++) drive(1'b1, 1'b0, 1'b1, 6'(a), 32'd0);
    idle(6);

    for (int n = 0; n < 20; n++) drive(1'b0, 1'b1, 1'b1, 6'(n), $urandom);
    idle(8);

    for (int k = 0; k < ND; k++) chk("drained", k, qsize(k), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
